// File: rtl/ram8_clr.sv
// 8 x 16-bit Hack-style RAM8 with a self-timed clear sequencer that zeroes every word.
// Define RAM8_CLR_REGOUT_EN for a registered read port (1-cycle latency, write-through).
module ram8_clr #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in,
  input  logic             load,
  input  logic [2:0]       address,
  input  logic             clr_req,
  output logic             busy,
  output logic [WIDTH-1:0] out
);

  localparam logic ST_IDLE  = 1'b0;
  localparam logic ST_CLEAR = 1'b1;

  logic             state;
  logic [2:0]       ptr;
  logic [WIDTH-1:0] mem [DEPTH];

  logic             wr_en;
  logic [2:0]       wr_addr;
  logic [WIDTH-1:0] wr_data;

  assign busy = (state == ST_CLEAR);

  // Single write port shared by the user load and the clear sweep; a clear request drops the load.
  always_comb begin
    wr_en   = 1'b0;
    wr_addr = address;
    wr_data = in;
    if (state == ST_CLEAR) begin
      wr_en   = 1'b1;
      wr_addr = ptr;
      wr_data = '0;
    end else if (load && !clr_req) begin
      wr_en = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      ptr   <= 3'd0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (clr_req) begin
            state <= ST_CLEAR;
            ptr   <= 3'd0;
          end
        end
        default: begin
          // ptr wraps 7 -> 0 on the final clear edge, leaving it ready for the next run.
          ptr <= ptr + 3'd1;
          if (ptr == 3'd7) state <= ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

`ifdef RAM8_CLR_REGOUT_EN
  // Write-through: a write to the addressed word shows up on the same edge it is captured.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out <= '0;
    end else if (wr_en && (wr_addr == address)) begin
      out <= wr_data;
    end else begin
      out <= mem[address];
    end
  end
`else
  assign out = mem[address];
`endif

endmodule

// File: tb/tb_ram8_clr.sv
// Randomised and directed bench for ram8_clr against a word-array reference model.
// Follows the RAM8_CLR_REGOUT_EN build setting for the expected read timing.
module tb_ram8_clr;

  logic        clk;
  logic        rst_n;
  logic [15:0] in;
  logic        load;
  logic [2:0]  address;
  logic        clr_req;
  logic        busy;
  logic [15:0] out;

  ram8_clr dut (
    .clk(clk), .rst_n(rst_n), .in(in), .load(load), .address(address),
    .clr_req(clr_req), .busy(busy), .out(out)
  );

  // clock/reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // reference model: word array plus "clear cycles remaining"
  logic [15:0] model_mem [8];
  int          clear_left;
  logic [15:0] model_out;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [15:0] exp_read();
`ifdef RAM8_CLR_REGOUT_EN
    return model_out;
`else
    return model_mem[address];
`endif
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 8; i++) model_mem[i] = 16'h0000;
    clear_left = 0;
    model_out  = 16'h0000;
  endtask

  // One clock edge of intended behaviour, from the current input values.
  task automatic model_edge();
    if (clear_left > 0) begin
      model_mem[8 - clear_left] = 16'h0000;
      clear_left--;
    end else if (clr_req) begin
      clear_left = 8;
    end else if (load) begin
      model_mem[address] = in;
    end
    model_out = model_mem[address];
  endtask

  task automatic check_now(input string tag);
    check({tag, "_out"}, out, exp_read());
    check({tag, "_busy"}, {15'd0, busy}, {15'd0, clear_left > 0});
  endtask

  // driver: apply inputs, check pre-edge, take the edge, check post-edge
  task automatic drive(input logic ld, input logic [2:0] a, input logic [15:0] d,
                       input logic c, input string tag);
    load = ld; address = a; in = d; clr_req = c;
    #1;
    check_now({tag, "_pre"});
    @(posedge clk);
    model_edge();
    #1;
    check_now({tag, "_post"});
  endtask

  task automatic do_reset();
    rst_n = 1'b0; load = 1'b0; clr_req = 1'b0; in = '0; address = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    #1;
  endtask

  logic [15:0] fill_vals [8];

  initial begin
    fill_vals = '{16'hAAAA, 16'hBBBB, 16'hCCCC, 16'hDDDD,
                  16'hEEEE, 16'hFFFF, 16'h1234, 16'h5678};
    do_reset();
    check("reset_busy", {15'd0, busy}, 16'h0000);
    check("reset_out", out, 16'h0000);
    for (int i = 0; i < 8; i++) drive(1'b0, 3'(i), 16'h0000, 1'b0, "rst_sweep");

    // fill and readback
    for (int i = 0; i < 8; i++) drive(1'b1, 3'(i), fill_vals[i], 1'b0, "fill");
    for (int i = 0; i < 8; i++) begin
      drive(1'b0, 3'(i), 16'h9999, 1'b0, "readback");
      check("readback_val", out, fill_vals[i]);
    end

    // clear sequence: count busy cycles, address 7 held
    begin
      int bcnt;
      bcnt = 0;
      drive(1'b0, 3'd7, 16'h0000, 1'b1, "clr_start");
      for (int i = 0; i < 20 && busy; i++) begin
        bcnt++;
        drive(1'b0, 3'd7, 16'h0000, 1'b0, "clr_run");
      end
      check("clr_busy_cycles", 16'(bcnt), 16'd8);
    end
    for (int i = 0; i < 8; i++) drive(1'b0, 3'(i), 16'h0000, 1'b0, "clr_sweep");

    // collisions: clear beats load, load during busy dropped, re-request ignored
    for (int i = 0; i < 8; i++) drive(1'b1, 3'(i), 16'h5A5A, 1'b0, "refill");
    drive(1'b1, 3'd3, 16'hBEEF, 1'b1, "coll_clr_load");
    drive(1'b1, 3'd5, 16'hCAFE, 1'b0, "coll_busy_load");
    drive(1'b0, 3'd5, 16'h0000, 1'b1, "coll_reclr");
    for (int i = 0; i < 12; i++) drive(1'b0, 3'd3, 16'h0000, 1'b0, "coll_run");
    check("coll_mem3", model_mem[3], 16'h0000);
    for (int i = 0; i < 8; i++) drive(1'b0, 3'(i), 16'h0000, 1'b0, "coll_sweep");

    // reset mid-clear
    for (int i = 0; i < 8; i++) drive(1'b1, 3'(i), 16'hFFFF, 1'b0, "ffill");
    drive(1'b0, 3'd6, 16'h0000, 1'b1, "mid_start");
    drive(1'b0, 3'd6, 16'h0000, 1'b0, "mid_c1");
    drive(1'b0, 3'd6, 16'h0000, 1'b0, "mid_c2");
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    check("mid_rst_busy", {15'd0, busy}, 16'h0000);
    check("mid_rst_out", out, 16'h0000);
    @(posedge clk);
    #3 rst_n = 1'b1;
    #1;
    for (int i = 0; i < 8; i++) drive(1'b0, 3'(i), 16'h0000, 1'b0, "mid_sweep");
    drive(1'b1, 3'd4, 16'h4321, 1'b0, "mid_write");
    drive(1'b0, 3'd4, 16'h0000, 1'b0, "mid_read");

`ifdef RAM8_CLR_REGOUT_EN
    drive(1'b1, 3'd2, 16'h1234, 1'b0, "reg_wr");
    check("reg_same_edge", out, 16'h1234);
    load = 1'b0; address = 3'd0; #1;
    check("reg_addr_hold", out, 16'h1234);
    @(posedge clk); model_edge(); #1;
    check("reg_addr_next", out, 16'h0000);
`endif

    // randomised traffic
    for (int n = 0; n < 400; n++) begin
      drive(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 16'($urandom),
            ($urandom_range(0, 19) == 0), "rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    errors++;
    $display("FAIL timeout t=%0t", $time);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ram8_clr.md
Name: ram8_clr

Overview:
- 8-word x 16-bit Hack-style RAM8 storage stage.
- Registered word array; read path is an 8-way 16-bit word select that sits directly downstream of the storage.
- Adds a self-timed clear sequencer that zeroes all 8 words, with a busy indication.
- Building block for RAM64 and up.

Parameters:
- WIDTH, 16, data word width in bits.
- DEPTH, 8, number of words; fixed at 8 (address is 3 bits). Other values are unsupported.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- in  input  WIDTH  write data.
- load  input  1  write enable; sampled on rising clk.
- address  input  3  word select for both read and write.
- clr_req  input  1  start a full-array clear; sampled on rising clk.
- busy  output  1  high while the clear sequence runs.
- out  output  WIDTH  read data, mem[address].

Behaviour:
- Reset (rst_n=0, asynchronous assert, synchronous release):
  - All 8 words = 0.
  - FSM = IDLE, clear pointer = 0, busy = 0.
  - out = 0 (reads a zeroed word).
- Read: out = mem[address], combinational with no clock latency.
  - A write becomes visible on out after the capturing rising edge (Hack semantics).
- FSM states: IDLE, CLEAR.
- IDLE:
  - load=1 at an edge: mem[address] <= in.
  - clr_req=1 at an edge: go to CLEAR, ptr <= 0; no word is written on that edge.
  - clr_req=1 and load=1 on the same edge: clear wins; the load is dropped, not deferred.
- CLEAR:
  - busy=1, driven combinationally from state.
  - Each edge: mem[ptr] <= 0, ptr <= ptr+1.
  - On the edge that writes ptr=7: return to IDLE, ptr <= 0.
  - CLEAR therefore lasts exactly 8 cycles; busy is high for 8 cycles.
  - load is ignored in CLEAR (write dropped); the caller must check busy.
  - clr_req is ignored in CLEAR (no restart, no extension).
  - Reads stay live in CLEAR: already-cleared words read 0, others read their old value.
- Pointer: 3-bit, wraps naturally from 7 to 0. It never exceeds 7 and has no out-of-range state.
- Reset asserted mid-CLEAR: immediate return to IDLE with all words 0; busy drops asynchronously.
- No X propagation: every word has a defined reset value, and address is always in range.

Optional Feature:
- Macro: RAM8_CLR_REGOUT_EN.
- Defined:
  - out is registered: out <= mem_next[address] at each rising edge, where mem_next includes that edge's write. Read latency is 1 cycle.
  - A write to the currently addressed word appears on out at the same edge it is captured.
  - The out register resets to 0.
- Undefined: combinational read as specified above (0-cycle latency).
- Write, clear and busy behaviour are identical in both builds.

Test Plan:
- Reset then read: rst_n=0 for 2 cycles, release; sweep address 0..7 -> out=0000 at every address, busy=0.
- Write/readback: write AAAA,BBBB,CCCC,DDDD,EEEE,FFFF,1234,5678 to addresses 0..7, one per cycle, load=1; then load=0 and sweep address -> out matches each value; with load=0 and in changed to 9999, out is unchanged.
- Clear sequence: after the fill, pulse clr_req for 1 cycle -> busy=1 for exactly 8 cycles; address=7 reads 5678 until the 8th clear edge, then 0000; all words 0000 afterwards; busy=0.
- Collisions: clr_req=1 and load=1 (address=3, in=BEEF) on the same edge -> mem[3]=0000 after the clear. load=1 (address=5, in=CAFE) during busy -> mem[5]=0000. A second clr_req mid-clear -> busy still ends after 8 cycles total.
- Reset mid-clear: fill with FFFF, start a clear, assert rst_n=0 at clear cycle 3 -> busy=0 immediately, all words 0000, the next write works normally.
- RAM8_CLR_REGOUT_EN build: write 1234 to address 2 with address held at 2 -> out=1234 at the write edge. Change address to 0 -> out updates one edge later.
